// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-register I2C master.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    TX_BYTE,
    RX_ACK,
    RSTART,
    RX_BYTE,
    TX_NACK,
    STOP
  } state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/i2c_qtimer.sv
// Quarter-phase tick generator: one tick every CLK_DIV clocks while run is high.
module i2c_qtimer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Single-register I2C master: one write or one read (with repeated START) per request.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] slv_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_data
);

  state_t     state, state_n;
  logic [1:0] q;
  logic [2:0] bit_cnt;
  logic [1:0] byte_cnt;
  logic [7:0] sh;
  logic       rw_r;
  logic [6:0] slv_r;
  logic [7:0] reg_r, wd_r;
  logic       ack_bit, err;
  logic       tick, q_last, sample, scl_mid;

  i2c_qtimer #(.CLK_DIV(CLK_DIV)) u_qtimer (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (busy),
    .tick (tick)
  );

  assign busy    = (state != IDLE);
  assign q_last  = tick && (q == Q3);
  assign sample  = tick && (q == Q2);
  assign scl_mid = (q == Q1) || (q == Q2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    scl_o   = 1'b1;
    sda_o   = 1'b1;
    case (state)
      IDLE: if (start) state_n = START;
      START: begin
        scl_o = (q != Q3);
        sda_o = (q == Q0);
        if (q_last) state_n = TX_BYTE;
      end
      TX_BYTE: begin
        scl_o = scl_mid;
        sda_o = sh[7];
        if (q_last && bit_cnt == 3'd7) state_n = RX_ACK;
      end
      RX_ACK: begin
        scl_o = scl_mid;
        if (q_last) begin
          if (ack_bit) state_n = STOP;
          else if (byte_cnt == 2'd0) state_n = TX_BYTE;
          else if (byte_cnt == 2'd1) state_n = (rw_r == RW_READ) ? RSTART : TX_BYTE;
          else state_n = (rw_r == RW_READ) ? RX_BYTE : STOP;
        end
      end
      RSTART: begin
        scl_o = scl_mid;
        sda_o = (q == Q0) || (q == Q1);
        if (q_last) state_n = TX_BYTE;
      end
      RX_BYTE: begin
        scl_o = scl_mid;
        if (q_last && bit_cnt == 3'd7) state_n = TX_NACK;
      end
      TX_NACK: begin
        scl_o = scl_mid;
        if (q_last) state_n = STOP;
      end
      STOP: begin
        scl_o = (q != Q0);
        sda_o = (q == Q2) || (q == Q3);
        if (q_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= Q0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      sh       <= '0;
      rw_r     <= RW_WRITE;
      slv_r    <= '0;
      reg_r    <= '0;
      wd_r     <= '0;
      ack_bit  <= 1'b0;
      err      <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      rd_data  <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) q <= Q0;
      else if (tick)     q <= q + 2'd1;

      if (state == IDLE && start) begin
        rw_r     <= rw;
        slv_r    <= slv_addr;
        reg_r    <= reg_addr;
        wd_r     <= wr_data;
        sh       <= {slv_addr, RW_WRITE};
        bit_cnt  <= '0;
        byte_cnt <= '0;
        err      <= 1'b0;
      end

      if (sample && state == RX_ACK)  ack_bit <= sda_i;
      if (sample && state == RX_BYTE) sh      <= {sh[6:0], sda_i};

      // RX shifts on the Q2 sample; TX shifts only once the bit's Q3 ends.
      if (q_last) begin
        case (state)
          TX_BYTE: begin
            bit_cnt <= bit_cnt + 3'd1;
            sh      <= {sh[6:0], 1'b0};
          end
          RX_BYTE: bit_cnt <= bit_cnt + 3'd1;
          RX_ACK: begin
            if (ack_bit) begin
              err <= 1'b1;
            end else begin
              if (byte_cnt != 2'd2) byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd0) sh <= reg_r;
              else if (byte_cnt == 2'd1 && rw_r == RW_WRITE) sh <= wd_r;
            end
          end
          RSTART: sh <= {slv_r, RW_READ};
          STOP: begin
            done    <= 1'b1;
            ack_err <= err;
            if (!err && rw_r == RW_READ) rd_data <= sh;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: CLK_DIV=4 and CLK_DIV=1 instances, each against a register-map slave model.
`timescale 1ns/1ps
module tb_i2c_master;
  import i2c_pkg::*;

  localparam int NI = 2;
  localparam logic [6:0] RESP_ADDR = 7'h53;
  localparam int OBS_MAX = 256;
  localparam logic [10:0] EV_S = {2'd1, 9'd0};
  localparam logic [10:0] EV_P = {2'd2, 9'd0};

  logic clk;
  logic rst_n;
  logic       start [NI], rw [NI];
  logic [6:0] slv_addr [NI];
  logic [7:0] reg_addr [NI], wr_data [NI], rd_data [NI];
  logic       sda_i [NI], scl_o [NI], sda_o [NI];
  logic       busy [NI], done [NI], ack_err [NI];
  logic       slv_drv [NI];

  i2c_master #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .rw(rw[0]), .slv_addr(slv_addr[0]),
    .reg_addr(reg_addr[0]), .wr_data(wr_data[0]), .sda_i(sda_i[0]), .scl_o(scl_o[0]),
    .sda_o(sda_o[0]), .busy(busy[0]), .done(done[0]), .ack_err(ack_err[0]), .rd_data(rd_data[0])
  );

  i2c_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .rw(rw[1]), .slv_addr(slv_addr[1]),
    .reg_addr(reg_addr[1]), .wr_data(wr_data[1]), .sda_i(sda_i[1]), .scl_o(scl_o[1]),
    .sda_o(sda_o[1]), .busy(busy[1]), .done(done[1]), .ack_err(ack_err[1]), .rd_data(rd_data[1])
  );

  assign sda_i[0] = sda_o[0] & ~slv_drv[0];
  assign sda_i[1] = sda_o[1] & ~slv_drv[1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Slave model and bus decoder; responds only to RESP_ADDR.
  logic        m_scl_p [NI], m_sda_p [NI];
  logic        m_s, m_d;
  int          m_bitn [NI], m_byte [NI];
  logic        m_addr_ok [NI], m_tx [NI], m_tx_pend [NI];
  logic [7:0]  m_sh [NI], m_ptr [NI];
  logic [7:0]  sregs [NI][256];
  logic [10:0] obs [NI][OBS_MAX];
  int          obs_n [NI], done_cnt [NI];

  task automatic log_ev(input int g, input logic [10:0] e);
    if (obs_n[g] < OBS_MAX) begin
      obs[g][obs_n[g]] = e;
      obs_n[g]++;
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      m_s = scl_o[g];
      m_d = sda_i[g];
      if (!rst_n) begin
        for (int r = 0; r < 256; r++) sregs[g][r] = 8'h00;
        sregs[g][8'h03] = 8'h3C;
        sregs[g][8'h10] = 8'hC3;
        m_bitn[g] = 0; m_byte[g] = 0; m_sh[g] = '0; m_ptr[g] = '0;
        m_addr_ok[g] = 1'b0; m_tx[g] = 1'b0; m_tx_pend[g] = 1'b0;
        slv_drv[g] = 1'b0; obs_n[g] = 0; done_cnt[g] = 0;
        m_s = 1'b1; m_d = 1'b1;
      end else begin
        if (done[g]) done_cnt[g]++;
        if (m_s && m_scl_p[g] && m_sda_p[g] && !m_d) begin
          log_ev(g, EV_S);
          m_bitn[g] = 0; m_byte[g] = 0; m_tx[g] = 1'b0; m_tx_pend[g] = 1'b0; slv_drv[g] = 1'b0;
        end else if (m_s && m_scl_p[g] && !m_sda_p[g] && m_d) begin
          log_ev(g, EV_P);
          m_bitn[g] = 0; m_byte[g] = 0; m_tx[g] = 1'b0; m_addr_ok[g] = 1'b0; slv_drv[g] = 1'b0;
        end else if (m_s && !m_scl_p[g]) begin
          if (m_bitn[g] < 8) begin
            m_sh[g] = {m_sh[g][6:0], m_d};
            m_bitn[g]++;
          end else begin
            log_ev(g, {2'd3, m_d, m_sh[g]});
            m_bitn[g] = 9;
          end
        end else if (!m_s && m_scl_p[g]) begin
          if (m_bitn[g] == 8) begin
            if (m_tx[g]) begin
              slv_drv[g] = 1'b0;
            end else begin
              if (m_byte[g] == 0) begin
                m_addr_ok[g] = (m_sh[g][7:1] == RESP_ADDR);
                m_tx_pend[g] = m_sh[g][0];
              end else if (m_addr_ok[g] && m_byte[g] == 1) begin
                m_ptr[g] = m_sh[g];
              end else if (m_addr_ok[g]) begin
                sregs[g][m_ptr[g]] = m_sh[g];
                m_ptr[g] = m_ptr[g] + 8'd1;
              end
              slv_drv[g] = m_addr_ok[g];
            end
          end else if (m_bitn[g] == 9) begin
            m_bitn[g] = 0;
            m_byte[g]++;
            m_tx[g] = m_tx_pend[g] && m_addr_ok[g];
            m_tx_pend[g] = 1'b0;
            slv_drv[g] = m_tx[g] && !sregs[g][m_ptr[g]][7];
          end else if (m_tx[g] && m_bitn[g] >= 1 && m_bitn[g] <= 7) begin
            slv_drv[g] = !sregs[g][m_ptr[g]][7 - m_bitn[g]];
          end
        end
      end
      m_scl_p[g] = m_s;
      m_sda_p[g] = m_d;
    end
  end

  typedef struct {
    logic       rw;
    logic [6:0] slv;
    logic [7:0] ra;
    logic [7:0] wd;
    logic       exp_err;
    logic [7:0] exp_rd;
    int         exp_lat;
  } vec_t;

  vec_t        vecs [7];
  logic [10:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          rd_idx [NI];
  int          t_c0 [NI];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_expected(input logic r, input logic [6:0] slv, input logic [7:0] ra,
                               input logic [7:0] wd, input logic nack, input logic [7:0] rdv);
    exp_q.push_back(EV_S);
    if (nack) begin
      exp_q.push_back({2'd3, 1'b1, slv, 1'b0});
    end else begin
      exp_q.push_back({2'd3, 1'b0, slv, 1'b0});
      exp_q.push_back({2'd3, 1'b0, ra});
      if (r == RW_WRITE) begin
        exp_q.push_back({2'd3, 1'b0, wd});
      end else begin
        exp_q.push_back(EV_S);
        exp_q.push_back({2'd3, 1'b0, slv, 1'b1});
        exp_q.push_back({2'd3, 1'b1, rdv});
      end
    end
    exp_q.push_back(EV_P);
  endtask

  task automatic check_bus(input int g, input string name);
    logic [10:0] e;
    int          n_exp;
    int          first;
    n_exp = exp_q.size();
    first = rd_idx[g];
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx[g] < obs_n[g]) check({name, "_ev"}, obs[g][rd_idx[g]], e);
      else check({name, "_ev_missing"}, 0, e);
      rd_idx[g]++;
    end
    check({name, "_ev_count"}, obs_n[g] - first, n_exp);
    rd_idx[g] = obs_n[g];
  endtask

  // Called at a negedge; start is accepted at the following posedge.
  task automatic drive_start(input int g, input logic r, input logic [6:0] slv,
                             input logic [7:0] ra, input logic [7:0] wd);
    start[g] = 1'b1; rw[g] = r; slv_addr[g] = slv; reg_addr[g] = ra; wr_data[g] = wd;
    t_c0[g] = cyc;
    @(posedge clk);
    #1;
    start[g] = 1'b0;
    check("busy_rise", busy[g], 1'b1);
  endtask

  task automatic wait_done(input int g, output int lat, output logic ok);
    ok = 1'b0;
    lat = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done[g]) begin
        lat = cyc - t_c0[g];
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int   lat;
    logic ok;
    int   dc0;

    vecs[0] = '{RW_WRITE, 7'h53, 8'h02, 8'hA5, 1'b0, 8'h00, 465};
    vecs[1] = '{RW_READ,  7'h53, 8'h03, 8'h00, 1'b0, 8'h3C, 625};
    vecs[2] = '{RW_WRITE, 7'h12, 8'h05, 8'h77, 1'b1, 8'h3C, 177};
    vecs[3] = '{RW_READ,  7'h53, 8'h02, 8'h00, 1'b0, 8'hA5, 625};
    vecs[4] = '{RW_READ,  7'h12, 8'h10, 8'h00, 1'b1, 8'hA5, 177};
    vecs[5] = '{RW_READ,  7'h53, 8'h10, 8'h00, 1'b0, 8'hC3, 625};
    vecs[6] = '{RW_WRITE, 7'h53, 8'h7F, 8'h00, 1'b0, 8'hC3, 465};

    for (int g = 0; g < NI; g++) begin
      start[g] = 1'b0; rw[g] = 1'b0; slv_addr[g] = '0; reg_addr[g] = '0; wr_data[g] = '0;
      rd_idx[g] = 0; t_c0[g] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check("rst_scl", scl_o[g], 1'b1);
      check("rst_sda", sda_o[g], 1'b1);
      check("rst_busy", busy[g], 1'b0);
      check("rst_done", done[g], 1'b0);
      check("rst_ack_err", ack_err[g], 1'b0);
      check("rst_rd_data", rd_data[g], 8'h00);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      push_expected(vecs[i].rw, vecs[i].slv, vecs[i].ra, vecs[i].wd, vecs[i].exp_err, vecs[i].exp_rd);
      @(negedge clk);
      drive_start(0, vecs[i].rw, vecs[i].slv, vecs[i].ra, vecs[i].wd);
      wait_done(0, lat, ok);
      check("vec_timeout", ok, 1'b1);
      check("vec_latency", lat, vecs[i].exp_lat);
      check("vec_ack_err", ack_err[0], vecs[i].exp_err);
      check("vec_rd_data", rd_data[0], vecs[i].exp_rd);
      check("vec_busy_fall", busy[0], 1'b0);
      check_bus(0, "vec_bus");
      @(negedge clk);
      check("vec_done_pulse", done[0], 1'b0);
    end

    // A start while busy must be dropped, and new inputs must not leak in.
    dc0 = done_cnt[0];
    push_expected(RW_WRITE, 7'h53, 8'h04, 8'h5A, 1'b0, 8'h00);
    @(negedge clk);
    drive_start(0, RW_WRITE, 7'h53, 8'h04, 8'h5A);
    repeat (40) @(negedge clk);
    start[0] = 1'b1; rw[0] = RW_READ; slv_addr[0] = 7'h12; reg_addr[0] = 8'h99; wr_data[0] = 8'hFF;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, lat, ok);
    check("busy_timeout", ok, 1'b1);
    check("busy_latency", lat, 465);
    check("busy_ack_err", ack_err[0], 1'b0);
    repeat (700) @(negedge clk);
    check("busy_done_count", done_cnt[0] - dc0, 1);
    check("busy_idle", busy[0], 1'b0);
    check_bus(0, "busy_bus");

    // CLK_DIV=1: second request issued in the done cycle of the first.
    push_expected(RW_WRITE, 7'h53, 8'h20, 8'h11, 1'b0, 8'h00);
    @(negedge clk);
    drive_start(1, RW_WRITE, 7'h53, 8'h20, 8'h11);
    wait_done(1, lat, ok);
    check("b2b_timeout_1", ok, 1'b1);
    check("b2b_latency_1", lat, 117);
    check("b2b_busy_in_done", busy[1], 1'b0);
    push_expected(RW_READ, 7'h53, 8'h20, 8'h00, 1'b0, 8'h11);
    drive_start(1, RW_READ, 7'h53, 8'h20, 8'h00);
    wait_done(1, lat, ok);
    check("b2b_timeout_2", ok, 1'b1);
    check("b2b_latency_2", lat, 157);
    check("b2b_ack_err", ack_err[1], 1'b0);
    check("b2b_rd_data", rd_data[1], 8'h11);
    check_bus(1, "b2b_bus");

    // Reset in the middle of the address byte while SDA is driven low.
    @(negedge clk);
    drive_start(0, RW_WRITE, 7'h53, 8'h02, 8'hA5);
    repeat (90) @(negedge clk);
    check("mid_pre_scl", scl_o[0], 1'b1);
    check("mid_pre_sda", sda_o[0], 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_scl", scl_o[0], 1'b1);
    check("mid_rst_sda", sda_o[0], 1'b1);
    check("mid_rst_busy", busy[0], 1'b0);
    check("mid_rst_done", done[0], 1'b0);
    check("mid_rst_rd_data", rd_data[0], 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_idx[0] = 0;
    rd_idx[1] = 0;
    repeat (4) @(negedge clk);
    check("post_rst_busy", busy[0], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
Single-clock I2C master that issues one-register write and read transactions toward the PPT controller's I2C slave. It is used for on-chip loopback and for test builds where one Tiny Tapeout tile configures another tile's register map over uio pins. It drives open-drain SCL and SDA through output-enable style pins and returns read data, a done pulse and an ACK-error flag.

Parameters:
CLK_DIV, 4, number of clk cycles per SCL quarter-phase; legal range is 1 or more; one SCL bit lasts 4*CLK_DIV clk cycles.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request; sampled only while busy=0
rw  input  1  0 = register write, 1 = register read; captured with start
slv_addr  input  7  target slave address, e.g. 7'h53; captured with start
reg_addr  input  8  register index; captured with start
wr_data  input  8  write payload; captured with start
sda_i  input  1  sampled SDA bus level
scl_o  output  1  1 = release SCL (pull-up high), 0 = drive low
sda_o  output  1  1 = release SDA, 0 = drive low; top level sets oe = !sda_o
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse at the end of a transaction
ack_err  output  1  valid with done; 1 = a slave NACK aborted the transaction
rd_data  output  8  read byte; updated only on a successful read

Behaviour:
- Reset values: scl_o=1, sda_o=1, busy=0, done=0, ack_err=0, rd_data=8'h00. Asserting reset mid-transaction releases both lines immediately, with no STOP sent.
- Quarter timer: counts 0..CLK_DIV-1. The FSM advances one quarter (Q0..Q3) on each terminal count.
- States: IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_NACK, STOP.
- START: Q0 SCL=1 SDA=1; Q1..Q2 SCL=1 SDA=0; Q3 SCL=0 SDA=0.
- Data or ACK bit: Q0 SCL=0 with SDA set to the bit value; Q1..Q2 SCL=1; sda_i is sampled on the last clk of Q2; Q3 SCL=0.
- Bits are sent MSB first. In RX_BYTE and RX_ACK the master holds sda_o=1.
- RSTART: Q0 SCL=0 SDA=1; Q1 SCL=1 SDA=1; Q2 SCL=1 SDA=0; Q3 SCL=0 SDA=0.
- STOP: Q0 SCL=0 SDA=0; Q1 SCL=1 SDA=0; Q2..Q3 SCL=1 SDA=1.
- Write sequence: START, {slv_addr,0}, ACK, reg_addr, ACK, wr_data, ACK, STOP. This totals 116 quarters.
- Read sequence: START, {slv_addr,0}, ACK, reg_addr, ACK, RSTART, {slv_addr,1}, ACK, 8 data bits, master NACK (SDA=1), STOP. This totals 156 quarters.
- A byte counter (0..2) together with the captured rw selects the next byte after each RX_ACK.
- A sampled ACK bit of 1 is a NACK. On NACK the FSM sets an internal err flag and goes straight to STOP. At completion done=1 and ack_err=1, and rd_data is unchanged.
- done is asserted for one cycle on the clk after STOP Q3 ends. busy falls in that same cycle. A new start is accepted in that same cycle or later.
- A start pulse while busy=1 is ignored and is not queued.
- Inputs are captured on acceptance, so later changes to them have no effect.
- Exact latency from the start-accept edge to the done pulse: 116*CLK_DIV+1 cycles for a write, 156*CLK_DIV+1 cycles for a read.
- The block does not support clock stretching or multi-master arbitration. SCL is never sampled.

Decomposition:
- Shared package i2c_pkg holds:
  - the state enum;
  - the RW_WRITE and RW_READ constants;
  - the quarter-index constants Q0..Q3.
- One natural sub-module, i2c_qtimer, implements the CLK_DIV quarter-phase tick generator.

Test Plan:
- Reset: rst_n=0 -> scl_o=1, sda_o=1, busy=0, done=0, rd_data=00. Pull reset low mid-byte -> both lines release in the same cycle.
- Write, with CLK_DIV=4 and an ACKing slave model: slv 53, reg 02, data A5 -> bus decodes A6, 02, A5 between START and STOP. done arrives 465 cycles after start with ack_err=0.
- Read: slv 53, reg 03, model returns 3C -> bus shows A6, 03, RSTART, A7, then master NACK. rd_data=3C, done arrives at cycle 625, ack_err=0.
- Address NACK: slv 12 with no responder -> STOP follows the first ACK slot. done=1, ack_err=1, rd_data keeps its previous value.
- Busy protection: pulse start again during a write -> the second request is ignored, exactly one done pulse is produced, and the bus shows only the first transaction.
- Back-to-back: issue start in the done cycle with CLK_DIV=1 -> the second transaction begins immediately. Both complete, with done 117 and 157 cycles after their accepts.
